// File: rtl/qgate_1q_engine.sv
// Sequential single-qubit gate engine: holds a 2^N complex state vector and applies
// H/X/Z/S to one target qubit, one amplitude pair per clock.
module qgate_1q_engine #(
  parameter int unsigned NUM_QUBITS  = 3,
  parameter int unsigned FIXED_WIDTH = 16,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned INV_SQRT2   = 181
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_ld_valid,
  input  logic [NUM_QUBITS-1:0]          i_ld_addr,
  input  logic [FIXED_WIDTH-1:0]         i_ld_re,
  input  logic [FIXED_WIDTH-1:0]         i_ld_im,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [1:0]                     i_cmd_gate,
  input  logic [$clog2(NUM_QUBITS)-1:0]  i_cmd_target,
  input  logic [NUM_QUBITS-1:0]          i_rd_addr,
  output logic [FIXED_WIDTH-1:0]         o_rd_re,
  output logic [FIXED_WIDTH-1:0]         o_rd_im,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err
);

  localparam int unsigned DEPTH = 1 << NUM_QUBITS;
  localparam int unsigned PAIRS = DEPTH / 2;
  localparam int unsigned TW    = $clog2(NUM_QUBITS);
  localparam int unsigned FW    = FIXED_WIDTH;
  localparam int unsigned PW    = 2 * FW + 2;

  typedef logic signed [FW-1:0] amp_t;

  localparam logic signed [PW-1:0] C_EXT   = PW'(INV_SQRT2);
  localparam logic signed [PW-1:0] RND     = PW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (FW - 1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);
  localparam amp_t                 AMP_MAX = amp_t'(2 ** (FW - 1) - 1);
  localparam amp_t                 AMP_MIN = ~AMP_MAX;
  localparam amp_t                 AMP_ONE = amp_t'(2 ** FRAC_BITS);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

  state_t                  r_state, w_state_next;
  amp_t                    r_re [DEPTH];
  amp_t                    r_im [DEPTH];
  logic [NUM_QUBITS-2:0]   r_k;
  logic [1:0]              r_gate;
  logic [TW-1:0]           r_target;
  logic                    r_err;
  amp_t                    r_rd_re, r_rd_im;

  logic                    w_accept, w_target_ok, w_last;
  logic [NUM_QUBITS-1:0]   w_kx, w_bit, w_mask, w_i0, w_i1;
  amp_t                    w_a_re, w_a_im, w_b_re, w_b_im;
  amp_t                    w_an_re, w_an_im, w_bn_re, w_bn_im;
  logic signed [FW:0]      w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  // (s * C + half) >>> FRAC_BITS, saturated to the amplitude range.
  function automatic amp_t h_scale(input logic signed [FW:0] s);
    logic signed [PW-1:0] p;
    p = PW'(s) * C_EXT;
    p = (p + RND) >>> FRAC_BITS;
    if (p > SAT_MAX) begin
      p = SAT_MAX;
    end else if (p < SAT_MIN) begin
      p = SAT_MIN;
    end
    return amp_t'(p);
  endfunction

  function automatic amp_t neg_sat(input amp_t v);
    return (v == AMP_MIN) ? AMP_MAX : -v;
  endfunction

  assign w_target_ok = (32'(i_cmd_target) < NUM_QUBITS);
  assign w_accept    = i_cmd_valid && (r_state == StIdle);
  assign w_last      = (r_k == (NUM_QUBITS - 1)'(PAIRS - 1));

  // Pair indices: insert a zero at the target bit position of k.
  always_comb begin
    w_kx   = {1'b0, r_k};
    w_bit  = NUM_QUBITS'(1) << r_target;
    w_mask = w_bit - NUM_QUBITS'(1);
    w_i0   = ((w_kx & ~w_mask) << 1) | (w_kx & w_mask);
    w_i1   = w_i0 | w_bit;
  end

  always_comb begin
    w_a_re   = r_re[w_i0];
    w_a_im   = r_im[w_i0];
    w_b_re   = r_re[w_i1];
    w_b_im   = r_im[w_i1];
    w_sum_re = (FW + 1)'(w_a_re) + (FW + 1)'(w_b_re);
    w_sum_im = (FW + 1)'(w_a_im) + (FW + 1)'(w_b_im);
    w_dif_re = (FW + 1)'(w_a_re) - (FW + 1)'(w_b_re);
    w_dif_im = (FW + 1)'(w_a_im) - (FW + 1)'(w_b_im);
    w_an_re  = w_a_re;
    w_an_im  = w_a_im;
    w_bn_re  = w_b_re;
    w_bn_im  = w_b_im;
    unique case (r_gate)
      2'b00: begin
        w_an_re = h_scale(w_sum_re);
        w_an_im = h_scale(w_sum_im);
        w_bn_re = h_scale(w_dif_re);
        w_bn_im = h_scale(w_dif_im);
      end
      2'b01: begin
        w_an_re = w_b_re;
        w_an_im = w_b_im;
        w_bn_re = w_a_re;
        w_bn_im = w_a_im;
      end
      2'b10: begin
        w_bn_re = neg_sat(w_b_re);
        w_bn_im = neg_sat(w_b_im);
      end
      2'b11: begin
        w_bn_re = neg_sat(w_b_im);
        w_bn_im = w_b_re;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    o_cmd_ready  = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_err        = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_cmd_valid) begin
          w_state_next = w_target_ok ? StRun : StFin;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_next = StFin;
        end
      end
      StFin: begin
        o_done       = 1'b1;
        o_err        = r_err;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k      <= '0;
      r_gate   <= '0;
      r_target <= '0;
      r_err    <= 1'b0;
      r_rd_re  <= '0;
      r_rd_im  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_re[i] <= (i == 0) ? AMP_ONE : '0;
        r_im[i] <= '0;
      end
    end else begin
      r_rd_re <= r_re[i_rd_addr];
      r_rd_im <= r_im[i_rd_addr];
      if (w_accept) begin
        r_gate   <= i_cmd_gate;
        r_target <= i_cmd_target;
        r_err    <= !w_target_ok;
        r_k      <= '0;
      end
      if (r_state == StRun) begin
        r_k        <= r_k + 1'b1;
        r_re[w_i0] <= w_an_re;
        r_im[w_i0] <= w_an_im;
        r_re[w_i1] <= w_bn_re;
        r_im[w_i1] <= w_bn_im;
      end
      if (i_ld_valid && (r_state == StIdle)) begin
        r_re[i_ld_addr] <= i_ld_re;
        r_im[i_ld_addr] <= i_ld_im;
      end
    end
  end

  assign o_rd_re = r_rd_re;
  assign o_rd_im = r_rd_im;

endmodule
